// File: rtl/instr_fmt_pkg.sv
// Shared RV32I format/opcode constants for the encode loader and the decode datapath.
package instr_fmt_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    // True when v is representable as a 'bits'-wide two's-complement value.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic [XLEN-1:0] hi;
        hi = XLEN'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational packer: decoded fields -> RV32I instruction word, plus immediate range flag.
// Range flag logic exists only when ENCODER_RANGE_CHECK_EN is defined; otherwise it is tied 0.
module imm_scatter
    import instr_fmt_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_c_o,
    output logic        range_err_c_o
);

    logic [31:0] word;
    logic        range_err;

    always_comb begin
        word = NOP_WORD;
        case (fmt_i)
            FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            FMT_I: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
            FMT_S: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
            FMT_B: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], op_i};
            FMT_U: word = {imm_i[31:12], rd_i, op_i};
            FMT_J: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
            default: word = NOP_WORD;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Flag immediates that lose information when truncated into the format's slots.
    always_comb begin
        range_err = 1'b0;
        case (fmt_i)
            FMT_R:        range_err = 1'b0;
            FMT_I, FMT_S: range_err = !fits_signed(imm_i, 12);
            FMT_B:        range_err = !fits_signed(imm_i, 13) || imm_i[0];
            FMT_J:        range_err = !fits_signed(imm_i, 21) || imm_i[0];
            FMT_U:        range_err = (imm_i[11:0] != 12'd0);
            default:      range_err = 1'b1;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign word_c_o      = word;
    assign range_err_c_o = range_err;

endmodule

// File: rtl/instr_encode_loader.sv
// Boot/test loader: encodes field bundles into RV32I words and streams them into instruction memory.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encode_loader
    import instr_fmt_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR,
    localparam int unsigned CNT_W      = $clog2(DEPTH_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             last_i,
    input  logic [2:0]       format_i,
    input  logic [6:0]       op_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic             error_o
);

    load_state_e      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             error_q, error_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0]      word_c;
    logic             range_err_c;

    imm_scatter #(
        .NOP_WORD (NOP_WORD)
    ) u_imm_scatter (
        .fmt_i         (format_i),
        .op_i          (op_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .imm_i         (imm_i),
        .word_c_o      (word_c),
        .range_err_c_o (range_err_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // count_q tracks accepted bundles, so the full condition is known at the accepting edge.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        error_d    = error_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    addr_d     = {base_addr_i[31:2], 2'b00};
                    count_d    = '0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (valid_i && ready_q) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = word_c;
                    addr_d     = addr_q + 32'd4;
                    count_d    = count_q + CNT_W'(1);
                    error_d    = error_q | range_err_c;
                    if (last_i) begin
                        state_d = ST_FLUSH;
                    end else if (count_d == CNT_W'(DEPTH_WORDS)) begin
                        state_d    = ST_FLUSH;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    assign ready_o    = ready_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign count_o    = count_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader (DEPTH_WORDS=4); expected writes are queued at accept time.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        valid_i;
    logic        ready_o;
    logic        last_i;
    logic [2:0]  format_i;
    logic [6:0]  op_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  count_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;
    logic        error_o;

`ifdef ENCODER_RANGE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_addr;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    instr_encode_loader #(
        .DEPTH_WORDS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .last_i      (last_i),
        .format_i    (format_i),
        .op_i        (op_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .error_o     (error_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_data", mem_data_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [31:0] base);
        base_addr_i = base;
        start_i     = 1'b1;
        exp_addr    = {base[31:2], 2'b00};
        tick();
        start_i     = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word);
        int budget;
        budget   = 20;
        format_i = fmt; op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm; last_i = last;
        valid_i  = 1'b1;
        while (!ready_o && budget > 0) begin
            tick();
            budget--;
        end
        if (!ready_o) begin
            check("accept_timeout", 32'(ready_o), 32'd1);
        end else begin
            exp_q.push_back('{addr: exp_addr, data: exp_word});
            exp_addr = exp_addr + 32'd4;
            tick();
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 10;
        while (!done_o && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_done"}, 32'(done_o), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; base_addr_i = '0; valid_i = 1'b0; last_i = 1'b0;
        format_i = '0; op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; imm_i = '0; exp_addr = '0;
        repeat (3) tick();
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        reset = 1'b0;
        tick();

        // valid held in IDLE without start is never accepted
        valid_i = 1'b1; format_i = 3'd1; op_i = 7'b0010011;
        repeat (3) tick();
        check("idle_ready", 32'(ready_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        valid_i = 1'b0;

        // single I-type word
        start_session(32'h0000_0100);
        check("run_ready", 32'(ready_o), 32'd1);
        check("run_busy", 32'(busy_o), 32'd1);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        check("flush_ready", 32'(ready_o), 32'd0);
        wait_done("single");
        check("single_count", 32'(count_o), 32'd1);
        tick();
        check("done_pulse", 32'(done_o), 32'd0);
        check("idle_again", 32'(busy_o), 32'd0);

        // back-to-back S then B
        start_session(32'h0000_0200);
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423);
        send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
        wait_done("sb");
        check("sb_count", 32'(count_o), 32'd2);
        check("sb_error", 32'(error_o), 32'd0);
        tick();

        // U then out-of-range J, with a start pulse mid-session that must be ignored
        start_session(32'h0000_1000);
        send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
        check("u_error", 32'(error_o), 32'd0);
        start_i = 1'b1; base_addr_i = 32'h0000_5000;
        send(3'd5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b1, 32'h8000_006F);
        start_i = 1'b0;
        check("j_error", 32'(error_o), 32'(EXP_ERR));
        wait_done("uj");
        check("uj_count", 32'(count_o), 32'd2);
        tick();

        // unsupported format and unaligned base
        start_session(32'h0000_0303);
        check("err_cleared", 32'(error_o), 32'd0);
        send(3'd7, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd7, 7'h7F, 32'hDEAD_BEEF, 1'b1, 32'h0000_0013);
        check("fmt7_error", 32'(error_o), 32'(EXP_ERR));
        wait_done("fmt7");
        tick();

        // overflow: four bundles fill the session, the fifth must be refused
        start_session(32'h0000_0400);
        for (int k = 0; k < 4; k++) begin
            send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1), 1'b0,
                 (32'(k + 1) << 20) | 32'h0000_0093);
        end
        check("ovf_ready", 32'(ready_o), 32'd0);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        valid_i = 1'b1;
        wait_done("ovf");
        valid_i = 1'b0;
        check("ovf_count", 32'(count_o), 32'd4);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        tick();

        // reset in RUN while a write is visible and another bundle is offered
        start_session(32'hFFFF_FFFC);
        check("start_clears_ovf", 32'(overflow_o), 32'd0);
        send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0, 32'h4031_00B3);
        format_i = 3'd1; valid_i = 1'b1; reset = 1'b1;
        tick();
        check("rst_mid_we", 32'(mem_we_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_ready", 32'(ready_o), 32'd0);
        check("rst_mid_count", 32'(count_o), 32'd0);
        check("rst_mid_data", mem_data_o, 32'd0);
        valid_i = 1'b0; reset = 1'b0;
        repeat (2) tick();

        // address wrap across 0xFFFFFFFC -> 0x0
        start_session(32'hFFFF_FFFC);
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0113);
        send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0000_0113);
        wait_done("wrap");
        repeat (2) tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the datapath's immediate decode.
- Accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready stream.
- Scatters the immediate back into its RV32I format positions and packs the 32-bit instruction word.
- Writes consecutive words into instruction memory from a programmable base address. Used by the boot/test loader ahead of the single-cycle core.

Parameters:
- DEPTH_WORDS, 64, maximum words written per load session before overflow.
- NOP_WORD, 32'h00000013, word written for an unsupported format code.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin session; sampled in IDLE only
- base_addr_i  in  32  byte address of first word; latched on start; bits[1:0] forced to 0
- valid_i  in  1  field bundle valid
- ready_o  out  1  encoder can accept a bundle
- last_i  in  1  final bundle of the session; qualified by valid_i&ready_o
- format_i  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 unsupported
- op_i  in  7  opcode
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3
- funct7_i  in  7
- imm_i  in  32  signed immediate (byte offset for B/J; full value for U)
- mem_we_o  out  1  instruction-memory write strobe
- mem_addr_o  out  32  byte write address
- mem_data_o  out  32  encoded word
- count_o  out  $clog2(DEPTH_WORDS+1)  words written this session
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at session end
- overflow_o  out  1  sticky: session hit DEPTH_WORDS without last_i
- error_o  out  1  sticky encode error (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state=IDLE, address/count 0. Reset mid-session aborts the session: no further mem_we_o from the next edge.
- States:
  - IDLE: on start_i, latch base address, clear count/overflow/error, go to RUN.
  - RUN: ready_o=1. On an accepted bundle with last_i, or when count reaches DEPTH_WORDS, go to FLUSH.
  - FLUSH: ready_o=0; wait one cycle for the final write, then go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- Handshake: transfer when valid_i & ready_o. ready_o is a registered state decode; it does not depend on valid_i.
- Latency: an accepted bundle in cycle N produces mem_we_o=1 in cycle N+1 with the registered address and word. Throughput is 1 word/cycle, back-to-back.
- Address: first write at base; +4 per write; 32-bit wrap-around permitted.
- count_o increments with each mem_we_o.
- Encoding (imm = imm_i):
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Fields not used by a format are ignored.
  - Unsupported format: write NOP_WORD.
- Overflow: when count reaches DEPTH_WORDS in RUN without last_i, set overflow_o, drop ready_o, end via FLUSH/DONE.
- start_i outside IDLE is ignored.
- valid_i in IDLE/FLUSH/DONE is not accepted.

Optional Feature:
- Macro ENCODER_RANGE_CHECK_EN.
- Defined: error_o sets, sticky until next start, on an accepted bundle when any of the following holds. The word is still written with truncated bits.
  - I/S: imm not a 12-bit signed value.
  - B: imm not 13-bit signed, or imm[0]!=0.
  - J: imm not 21-bit signed, or imm[0]!=0.
  - U: imm[11:0]!=0.
  - Format is 6 or 7.
- Undefined: no checker logic; error_o is constant 0.

Decomposition:
- Shared package instr_fmt_pkg: format code constants; opcode constants (shared with the decode side); NOP constant.
- One sub-module, imm_scatter: combinational format+fields -> word, plus range-error flag. The top level holds the FSM, output register and counters.

Test Plan:
- Start base=0x100; I: op=0010011, rd=1, rs1=0, f3=0, imm=5, last=1 -> one write addr 0x100 data 0x00500093 at N+1, then done_o pulse, count_o=1.
- Back-to-back, valid held high: S (op=0100011, f3=2, rs1=1, rs2=2, imm=8), then B (op=1100011, rs1=rs2=0, f3=0, imm=-4, last) -> 0x0020A423 @base, 0xFE000EE3 @base+4 on consecutive cycles.
- U: op=0110111, rd=5, imm=0x12345000 -> 0x123452B7. Same session J: op=1101111, imm=0x00100000 -> error_o=1 only with ENCODER_RANGE_CHECK_EN.
- DEPTH_WORDS=4, 5 bundles and no last -> exactly 4 writes, overflow_o=1, ready_o low after the 4th accept, done_o pulses.
- reset asserted in RUN with a write pending -> mem_we_o=0 next cycle, all outputs 0, IDLE. Also: start_i during RUN is ignored.
- format=7 -> writes 0x00000013. Valid_i held in IDLE without start -> no write, ready_o=0.
